// File: rtl/cmos_cfg_if.sv
// Signal bundle between the CMOS config sequencer, its table ROM,
// the I2C write engine and the capture-path gate.
interface cmos_cfg_if #(
  parameter int AW = 8
);
  logic          start;
  logic [AW-1:0] lut_addr;
  logic [23:0]   lut_data;
  logic          i2c_req;
  logic [15:0]   i2c_reg_addr;
  logic [7:0]    i2c_wr_data;
  logic          i2c_done;
  logic          i2c_ack_err;
  logic          cfg_busy;
  logic          cfg_done;
  logic          cfg_err;

  // i2c_req is a one-cycle pulse; reg_addr/wr_data hold from that cycle until the
  // one-cycle i2c_done pulse, which alone qualifies i2c_ack_err. lut_data follows lut_addr by one cycle.
  modport master (
    input  start, lut_data, i2c_done, i2c_ack_err,
    output lut_addr, i2c_req, i2c_reg_addr, i2c_wr_data, cfg_busy, cfg_done, cfg_err
  );

  modport slave (
    output start, lut_data, i2c_done, i2c_ack_err,
    input  lut_addr, i2c_req, i2c_reg_addr, i2c_wr_data, cfg_busy, cfg_done, cfg_err
  );
endinterface

// File: rtl/cmos_cfg_seq.sv
// CMOS sensor configuration sequencer: walks the register table, issues I2C
// writes with NACK retry, inserts power-up and table-coded delays.
module cmos_cfg_seq #(
  parameter int          LUT_SIZE  = 200,
  parameter int          AW        = 8,
  parameter int          PWRUP_CYC = 1000000,
  parameter int          DLY_UNIT  = 50000,
  parameter logic [15:0] DLY_MARK  = 16'hFFFF,
  parameter int          MAX_RETRY = 3,
  parameter int          RETRY_GAP = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  cmos_cfg_if.master bus,
  output logic [3:0] dbg_state_o
);

  localparam int PW_W = $clog2(PWRUP_CYC + 1);
  localparam int DL_W = 8 + $clog2(DLY_UNIT + 1);
  localparam int GP_W = $clog2(RETRY_GAP + 1);
  localparam int CW_A = (PW_W > DL_W) ? PW_W : DL_W;
  localparam int CW   = (CW_A > GP_W) ? CW_A : GP_W;
  localparam int RW_R = $clog2(MAX_RETRY + 1);
  localparam int RW   = (RW_R > 0) ? RW_R : 1;

  typedef enum logic [3:0] {
    ST_PWRUP  = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_ISSUE  = 4'd3,
    ST_WAIT   = 4'd4,
    ST_DELAY  = 4'd5,
    ST_GAP    = 4'd6,
    ST_NEXT   = 4'd7,
    ST_DONE   = 4'd8,
    ST_FAIL   = 4'd9
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic          req_q, req_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [AW-1:0] lut_addr_q, lut_addr_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_PWRUP;
      idx_q      <= '0;
      cnt_q      <= '0;
      retry_q    <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      lut_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      req_q      <= req_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      lut_addr_q <= lut_addr_d;
    end
  end

  // One shared counter serves power-up, delay and retry-gap timing; they never overlap.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      ST_PWRUP: begin
        if (cnt_q == CW'(PWRUP_CYC - 1)) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = ST_FETCH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        if (bus.lut_data[23:8] == DLY_MARK) begin
          if (bus.lut_data[7:0] == 8'd0) begin
            state_d = ST_NEXT;
          end else begin
            cnt_d   = CW'(bus.lut_data[7:0]) * CW'(DLY_UNIT);
            state_d = ST_DELAY;
          end
        end else begin
          addr_d  = bus.lut_data[23:8];
          data_d  = bus.lut_data[7:0];
          retry_d = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.i2c_done) begin
          if (!bus.i2c_ack_err) begin
            state_d = ST_NEXT;
          end else if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + RW'(1);
            cnt_d   = '0;
            state_d = ST_GAP;
          end else begin
            state_d = ST_FAIL;
          end
        end
      end
      ST_GAP: begin
        if (cnt_q == CW'(RETRY_GAP - 1)) begin
          cnt_d   = '0;
          state_d = ST_ISSUE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DELAY: begin
        if (cnt_q <= CW'(1)) begin
          cnt_d   = '0;
          state_d = ST_NEXT;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_NEXT: begin
        if (idx_q == AW'(LUT_SIZE - 1)) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + AW'(1);
          state_d = ST_FETCH;
        end
      end
      ST_DONE, ST_FAIL: begin
        if (bus.start) begin
          idx_d   = '0;
          cnt_d   = '0;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_PWRUP;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with state_q.
  always_comb begin
    req_d      = (state_d == ST_ISSUE);
    busy_d     = (state_d != ST_DONE) && (state_d != ST_FAIL);
    done_d     = (state_d == ST_DONE);
    err_d      = (state_d == ST_FAIL);
    lut_addr_d = idx_d;
  end

  assign bus.lut_addr     = lut_addr_q;
  assign bus.i2c_req      = req_q;
  assign bus.i2c_reg_addr = addr_q;
  assign bus.i2c_wr_data  = data_q;
  assign bus.cfg_busy     = busy_q;
  assign bus.cfg_done     = done_q;
  assign bus.cfg_err      = err_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_cmos_cfg_seq.sv
// Directed bench for cmos_cfg_seq: ROM and I2C engine models, write scoreboard,
// nominal / NACK / persistent NACK / restart / reset-in-WAIT / zero-delay scenarios.
module tb_cmos_cfg_seq;
  localparam int AW        = 8;
  localparam int LUT_SIZE  = 4;
  localparam int PWRUP_CYC = 10;
  localparam int DLY_UNIT  = 4;
  localparam int MAX_RETRY = 2;
  localparam int RETRY_GAP = 3;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] dbg_state;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cmos_cfg_if #(.AW(AW)) bus ();

  cmos_cfg_seq #(
    .LUT_SIZE (LUT_SIZE),
    .AW       (AW),
    .PWRUP_CYC(PWRUP_CYC),
    .DLY_UNIT (DLY_UNIT),
    .DLY_MARK (16'hFFFF),
    .MAX_RETRY(MAX_RETRY),
    .RETRY_GAP(RETRY_GAP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  // ---------------- ROM model ----------------
  logic [23:0] rom [LUT_SIZE];
  always @(posedge clk) bus.lut_data <= rom[bus.lut_addr];

  // ---------------- I2C engine model ----------------
  int          nack_base  = 0;
  int          nack_limit = 0;
  int          nack_total = 0;
  int          req_cnt    = 0;
  int          eng_cnt    = 0;
  logic        eng_nack   = 1'b0;
  int          last_nack_cyc = 0;
  logic [23:0] req_log [$];
  int          req_cyc_q [$];
  int          done_cyc_q [$];

  always @(negedge clk) begin
    bus.i2c_done    = 1'b0;
    bus.i2c_ack_err = 1'b0;
    if (eng_cnt != 0) begin
      eng_cnt = eng_cnt - 1;
      if (eng_cnt == 0) begin
        bus.i2c_done    = 1'b1;
        bus.i2c_ack_err = eng_nack;
        done_cyc_q.push_back(cyc);
        if (eng_nack) last_nack_cyc = cyc;
      end
    end
    if (bus.i2c_req === 1'b1) begin
      req_log.push_back({bus.i2c_reg_addr, bus.i2c_wr_data});
      req_cyc_q.push_back(cyc);
      req_cnt  = req_cnt + 1;
      eng_cnt  = 5;
      eng_nack = (bus.i2c_reg_addr == 16'h00AB) && ((nack_total - nack_base) < nack_limit);
      if (eng_nack) nack_total = nack_total + 1;
    end
  end

  // ---------------- scoreboard ----------------
  logic [23:0] exp_q [$];
  int          rd_ptr = 0;
  int          n_chk  = 0;
  int          n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_writes(input string tag);
    while (exp_q.size() > 0) begin
      if (rd_ptr < req_log.size()) begin
        chk({tag, "_write"}, {8'h00, req_log[rd_ptr]}, {8'h00, exp_q.pop_front()});
        rd_ptr++;
      end else begin
        chk({tag, "_write_missing"}, 32'd0, {8'h00, exp_q.pop_front()});
      end
    end
    chk({tag, "_extra_writes"}, req_log.size() - rd_ptr, 0);
    rd_ptr = req_log.size();
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int b;
    b = 0;
    while (!(bus.cfg_done || bus.cfg_err) && b < 1000) begin
      @(negedge clk);
      b++;
    end
    if (b >= 1000) chk({tag, "_end_timeout"}, 0, 1);
  endtask

  task automatic wait_reqs(input int n, input string tag);
    int b;
    b = 0;
    while (req_cnt < n && b < 1000) begin
      @(negedge clk);
      b++;
    end
    if (b >= 1000) chk({tag, "_req_timeout"}, 0, 1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_busy"},     bus.cfg_busy, 0);
    chk({tag, "_done"},     bus.cfg_done, 0);
    chk({tag, "_err"},      bus.cfg_err, 0);
    chk({tag, "_req"},      bus.i2c_req, 0);
    chk({tag, "_lut_addr"}, bus.lut_addr, 0);
    chk({tag, "_reg_addr"}, bus.i2c_reg_addr, 0);
    chk({tag, "_wr_data"},  bus.i2c_wr_data, 0);
  endtask

  task automatic push_nominal();
    exp_q.push_back(24'h123456);
    exp_q.push_back(24'h00ABCD);
    exp_q.push_back(24'h010001);
  endtask

  // ---------------- directed sequence ----------------
  int rel, base, dbase, s;

  initial begin
    bus.start = 1'b0;
    rom[0] = 24'h123456;
    rom[1] = 24'hFFFF02;
    rom[2] = 24'h00ABCD;
    rom[3] = 24'h010001;
    tick(3);
    chk_reset_outs("rst");
    chk("rst_state", dbg_state, 0);

    // 1: nominal run from reset
    rst_n = 1'b1;
    rel   = cyc;
    base  = req_log.size();
    dbase = done_cyc_q.size();
    push_nominal();
    tick(2);
    chk("t1_pwrup_busy", bus.cfg_busy, 1);
    chk("t1_pwrup_state", dbg_state, 0);
    wait_end("t1");
    chk("t1_done", bus.cfg_done, 1);
    chk("t1_busy", bus.cfg_busy, 0);
    chk("t1_err",  bus.cfg_err, 0);
    if (req_log.size() >= base + 2 && done_cyc_q.size() > dbase) begin
      chk("t1_pwrup_latency", (req_cyc_q[base] - rel) >= PWRUP_CYC, 1);
      chk("t1_delay_gap", (req_cyc_q[base + 1] - done_cyc_q[dbase]) >= 8, 1);
    end
    check_writes("t1");

    // 4: restart from DONE, then a start pulse mid-run that must be ignored
    base = req_log.size();
    push_nominal();
    s = cyc;
    pulse_start();
    chk("t4_done_drop", bus.cfg_done, 0);
    chk("t4_busy", bus.cfg_busy, 1);
    wait_reqs(base + 1, "t4");
    if (req_log.size() > base) chk("t4_no_pwrup", (req_cyc_q[base] - s) <= 4, 1);
    pulse_start();
    wait_end("t4");
    chk("t4_done", bus.cfg_done, 1);
    check_writes("t4");

    // 2: single NACK on 00AB, retried after the gap
    nack_base  = nack_total;
    nack_limit = 1;
    base = req_log.size();
    exp_q.push_back(24'h123456);
    exp_q.push_back(24'h00ABCD);
    exp_q.push_back(24'h00ABCD);
    exp_q.push_back(24'h010001);
    pulse_start();
    wait_end("t2");
    chk("t2_done", bus.cfg_done, 1);
    chk("t2_err",  bus.cfg_err, 0);
    if (req_log.size() >= base + 3) chk("t2_retry_gap", (req_cyc_q[base + 2] - last_nack_cyc) >= RETRY_GAP, 1);
    check_writes("t2");

    // 3: persistent NACK exhausts the retries
    nack_base  = nack_total;
    nack_limit = 100;
    exp_q.push_back(24'h123456);
    exp_q.push_back(24'h00ABCD);
    exp_q.push_back(24'h00ABCD);
    exp_q.push_back(24'h00ABCD);
    pulse_start();
    wait_end("t3");
    chk("t3_err",  bus.cfg_err, 1);
    chk("t3_done", bus.cfg_done, 0);
    chk("t3_busy", bus.cfg_busy, 0);
    chk("t3_lut_addr", bus.lut_addr, 2);
    tick(30);
    chk("t3_err_held", bus.cfg_err, 1);
    check_writes("t3");

    // 6: zero-delay entry, restarted from FAIL
    nack_limit = 0;
    rom[1] = 24'hFFFF00;
    base  = req_log.size();
    dbase = done_cyc_q.size();
    push_nominal();
    pulse_start();
    chk("t6_err_clear", bus.cfg_err, 0);
    wait_end("t6");
    chk("t6_done", bus.cfg_done, 1);
    if (req_log.size() >= base + 2 && done_cyc_q.size() > dbase)
      chk("t6_zero_gap", (req_cyc_q[base + 1] - done_cyc_q[dbase]) <= 7, 1);
    check_writes("t6");

    // 5: reset while waiting for the engine, late done lands after release
    rom[1] = 24'hFFFF02;
    base = req_log.size();
    pulse_start();
    wait_reqs(base + 1, "t5");
    tick(2);
    rst_n = 1'b0;
    tick(2);
    chk_reset_outs("t5_rst");
    rst_n  = 1'b1;
    rel    = cyc;
    rd_ptr = req_log.size();
    base   = req_log.size();
    push_nominal();
    tick(6);
    chk("t5_pwrup_state", dbg_state, 0);
    chk("t5_no_req", req_log.size() - base, 0);
    chk("t5_done_low", bus.cfg_done, 0);
    wait_end("t5");
    chk("t5_done", bus.cfg_done, 1);
    if (req_log.size() > base) chk("t5_pwrup_latency", (req_cyc_q[base] - rel) >= PWRUP_CYC, 1);
    check_writes("t5");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
